// File: rtl/bert_pkg.sv
// rtl/bert_pkg.sv - PRBS-13 constants, sequencer states and LFSR step helpers
package bert_pkg;

  localparam int PRBS_W = 13;
  // Feedback taps at bits 12, 3, 2 and 0
  localparam logic [PRBS_W-1:0] PRBS13_TAPS = 13'h100D;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SYNC,
    MEAS,
    DONE
  } state_t;

  function automatic logic prbs13_pred(input logic [PRBS_W-1:0] s);
    return ^(s & PRBS13_TAPS);
  endfunction

  function automatic logic [PRBS_W-1:0] prbs13_next(input logic [PRBS_W-1:0] s,
                                                    input logic b);
    return {s[PRBS_W-2:0], b};
  endfunction

endpackage

// File: rtl/prbs13_ref.sv
// rtl/prbs13_ref.sv - local PRBS-13 reference LFSR, rx-driven or free-running
module prbs13_ref
  import bert_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic shift,
  input  logic free_run,
  input  logic din,
  output logic pred,
  output logic zero
);

  logic [PRBS_W-1:0] s;

  assign pred = prbs13_pred(s);
  assign zero = (s == '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      s <= '0;
    end else if (shift) begin
      s <= prbs13_next(s, free_run ? pred : din);
    end
  end

endmodule

// File: rtl/bert_seq_ctrl.sv
// rtl/bert_seq_ctrl.sv - PRBS-13 BERT sequencer: load, sync, measure, report
module bert_seq_ctrl
  import bert_pkg::*;
#(
  parameter logic [12:0] SEED         = 13'h000F,
  parameter int          SYNC_LEN     = 32,
  parameter int          SYNC_TIMEOUT = 4096,
  parameter int          WIN_LEN      = 64,
  parameter int          LOSS_ERRS    = 8,
  parameter int          CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] test_len,
  input  logic             rx_valid,
  input  logic             rx_bit,
  output logic             gen_load,
  output logic [12:0]      gen_seed,
  output logic             gen_en,
  output logic             busy,
  output logic             locked,
  output logic             done,
  output logic             sync_fail,
  output logic [7:0]       resync_cnt,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int MATCH_W = $clog2(SYNC_LEN + 1);
  localparam int TOUT_W  = $clog2(SYNC_TIMEOUT + 1);
  localparam int WIN_W   = $clog2(WIN_LEN + 1);
  localparam int WERR_W  = $clog2(LOSS_ERRS + 1);
  localparam logic [12:0] SEED_EFF = (SEED == 13'h0000) ? 13'h0001 : SEED;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   len_q;
  logic [3:0]         fill;
  logic [MATCH_W-1:0] match_cnt;
  logic [TOUT_W-1:0]  tout_cnt;
  logic [WIN_W-1:0]   win_cnt;
  logic [WERR_W-1:0]  win_err;
  logic [WERR_W-1:0]  win_err_inc;
  logic [CNT_W-1:0]   bit_inc, err_inc;
  logic               pred, s_zero;
  logic               sync_bit, meas_bit, match_ok, err;
  logic               lock_hit, tout_hit, loss_hit, len_hit, restart;

  assign gen_seed = SEED_EFF;

  prbs13_ref u_ref (
    .clock    (clock),
    .reset    (reset),
    .shift    (sync_bit || meas_bit),
    .free_run (state == MEAS),
    .din      (rx_bit),
    .pred     (pred),
    .zero     (s_zero)
  );

  // abort outranks everything, including the rx bit arriving with it
  assign sync_bit = rx_valid && !abort && (state == SYNC);
  assign meas_bit = rx_valid && !abort && (state == MEAS);
  assign restart  = start && !abort && (state == IDLE || state == DONE);

  // An all-zero register predicts zero forever, so it never counts as a match
  assign match_ok = (fill == 4'd13) && !s_zero && (rx_bit == pred);
  assign lock_hit = sync_bit && match_ok && (match_cnt == MATCH_W'(SYNC_LEN - 1));
  assign tout_hit = sync_bit && (tout_cnt == TOUT_W'(SYNC_TIMEOUT - 1));

  assign err         = rx_bit ^ pred;
  assign bit_inc     = (bit_count == '1) ? bit_count : bit_count + 1'b1;
  assign err_inc     = (err_count == '1 || !err) ? err_count : err_count + 1'b1;
  assign win_err_inc = win_err + WERR_W'(err);
  assign loss_hit    = meas_bit && (win_err_inc == WERR_W'(LOSS_ERRS));
  assign len_hit     = meas_bit && (bit_inc == len_q);

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start) state_nxt = LOAD;
        LOAD:       state_nxt = (len_q == '0) ? DONE : SYNC;
        SYNC: begin
          if (lock_hit)      state_nxt = MEAS;
          else if (tout_hit) state_nxt = DONE;
        end
        MEAS: begin
          if (len_hit)       state_nxt = DONE;
          else if (loss_hit) state_nxt = SYNC;
        end
        default:    state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      gen_load   <= 1'b0;
      gen_en     <= 1'b0;
      busy       <= 1'b0;
      locked     <= 1'b0;
      done       <= 1'b0;
      sync_fail  <= 1'b0;
      resync_cnt <= '0;
      bit_count  <= '0;
      err_count  <= '0;
      len_q      <= '0;
      fill       <= '0;
      match_cnt  <= '0;
      tout_cnt   <= '0;
      win_cnt    <= '0;
      win_err    <= '0;
    end else begin
      state    <= state_nxt;
      gen_load <= (state_nxt == LOAD);
      gen_en   <= (state_nxt == SYNC) || (state_nxt == MEAS);
      busy     <= (state_nxt == LOAD) || (state_nxt == SYNC) || (state_nxt == MEAS);
      locked   <= (state_nxt == MEAS);
      done     <= (state_nxt == DONE);

      if (state_nxt == SYNC && state != SYNC) begin
        fill      <= '0;
        tout_cnt  <= '0;
        match_cnt <= '0;
      end else if (sync_bit) begin
        fill      <= (fill == 4'd13) ? fill : fill + 4'd1;
        tout_cnt  <= tout_cnt + 1'b1;
        match_cnt <= match_ok ? match_cnt + 1'b1 : '0;
        if (tout_hit && !lock_hit) sync_fail <= 1'b1;
      end

      if (state_nxt == MEAS && state != MEAS) begin
        win_cnt <= '0;
        win_err <= '0;
      end else if (meas_bit) begin
        bit_count <= bit_inc;
        err_count <= err_inc;
        if (win_cnt == WIN_W'(WIN_LEN - 1)) begin
          win_cnt <= '0;
          win_err <= '0;
        end else begin
          win_cnt <= win_cnt + 1'b1;
          win_err <= win_err_inc;
        end
        // finishing the test on this bit takes precedence over a resync
        if (loss_hit && !len_hit && resync_cnt != 8'hFF)
          resync_cnt <= resync_cnt + 8'd1;
      end

      if (restart) begin
        len_q      <= test_len;
        bit_count  <= '0;
        err_count  <= '0;
        resync_cnt <= '0;
        sync_fail  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bert_seq_ctrl.sv
// tb/tb_bert_seq_ctrl.sv - directed self-checking bench for bert_seq_ctrl
module tb_bert_seq_ctrl;

  localparam int MAX_CYC = 12000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] test_len = '0;
  logic        rx_valid = 1'b0;
  logic        rx_bit = 1'b0;
  logic        gen_load, gen_en, busy, locked, done, sync_fail;
  logic [12:0] gen_seed;
  logic [7:0]  resync_cnt;
  logic [31:0] bit_count, err_count;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          load_pulses = 0;
  logic [12:0] g;
  int          tx_idx, meas_idx, lock_at, cyc;
  logic [31:0] err_at_unlock;

  bert_seq_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .test_len   (test_len),
    .rx_valid   (rx_valid),
    .rx_bit     (rx_bit),
    .gen_load   (gen_load),
    .gen_seed   (gen_seed),
    .gen_en     (gen_en),
    .busy       (busy),
    .locked     (locked),
    .done       (done),
    .sync_fail  (sync_fail),
    .resync_cnt (resync_cnt),
    .bit_count  (bit_count),
    .err_count  (err_count)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    if (gen_load) load_pulses++;
  endtask

  task automatic start_test(input logic [31:0] len);
    int p0;
    p0 = load_pulses;
    test_len = len;
    start = 1'b1;
    tick();
    start = 1'b0;
    test_len = 32'd5;
    tick();
    check_eq("gen_load_once", load_pulses - p0, 1);
  endtask

  // Drives the ideal generator stream; flips chosen by absolute valid-bit index
  task automatic run(input bit gap, input int f0, input int f1, input int f2,
                     input int b_lo, input int b_hi, input bit stuck, input int stop_meas);
    logic b, lk;
    bit   v;
    tx_idx = 0; meas_idx = 0; lock_at = -1; cyc = 0;
    err_at_unlock = 32'hFFFF_FFFF;
    g = 13'h000F;
    while (!done && cyc < MAX_CYC) begin
      if (stop_meas >= 0 && locked && meas_idx == stop_meas) break;
      if (locked && lock_at < 0) lock_at = tx_idx;
      v = !gap || (cyc % 2 == 0);
      rx_valid = v;
      if (v) begin
        b = g[12] ^ g[3] ^ g[2] ^ g[0];
        g = {g[11:0], b};
        if (tx_idx == f0 || tx_idx == f1 || tx_idx == f2 || (tx_idx >= b_lo && tx_idx <= b_hi))
          b = ~b;
        if (stuck) b = 1'b0;
        rx_bit = b;
        if (locked) meas_idx++;
        tx_idx++;
      end
      lk = locked;
      tick();
      cyc++;
      if (lk && !locked && !done && err_at_unlock == 32'hFFFF_FFFF) err_at_unlock = err_count;
    end
    rx_valid = 1'b0;
    if (cyc >= MAX_CYC) check_eq("run_budget", cyc, 0);
  endtask

  initial begin
    repeat (3) tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_gen_load", gen_load, 0);
    check_eq("rst_gen_en", gen_en, 0);
    check_eq("rst_bit_count", bit_count, 0);
    check_eq("rst_gen_seed", gen_seed, 32'h000F);
    reset = 1'b1;
    tick();

    // clean loopback
    start_test(1000);
    check_eq("sync_gen_en", gen_en, 1);
    check_eq("sync_busy", busy, 1);
    run(0, -1, -1, -1, -1, -2, 0, -1);
    check_eq("clean_lock_at", lock_at, 45);
    check_eq("clean_bits", bit_count, 1000);
    check_eq("clean_errs", err_count, 0);
    check_eq("clean_resync", resync_cnt, 0);
    check_eq("clean_done", done, 1);
    check_eq("clean_sync_fail", sync_fail, 0);
    check_eq("done_gen_en", gen_en, 0);
    check_eq("done_busy", busy, 0);

    // single-bit errors at measured bits 100, 500, 900
    start_test(1000);
    run(0, 145, 545, 945, -1, -2, 0, -1);
    check_eq("single_errs", err_count, 3);
    check_eq("single_resync", resync_cnt, 0);
    check_eq("single_bits", bit_count, 1000);

    // burst over measured bits 200..209; the last two land in SYNC
    start_test(1000);
    run(0, -1, -1, -1, 245, 254, 0, -1);
    check_eq("burst_err_held", err_at_unlock, 8);
    check_eq("burst_resync", resync_cnt, 1);
    check_eq("burst_errs", err_count, 8);
    check_eq("burst_bits", bit_count, 1000);
    check_eq("burst_done", done, 1);

    // gapped rx_valid
    start_test(1000);
    run(1, -1, -1, -1, -1, -2, 0, -1);
    check_eq("gap_lock_at", lock_at, 45);
    check_eq("gap_bits", bit_count, 1000);
    check_eq("gap_errs", err_count, 0);
    check_eq("gap_resync", resync_cnt, 0);

    // stuck-zero input
    start_test(1000);
    run(0, -1, -1, -1, -1, -2, 1, -1);
    check_eq("stuck_never_locked", lock_at, 32'hFFFF_FFFF);
    check_eq("stuck_valid_bits", tx_idx, 4096);
    check_eq("stuck_done", done, 1);
    check_eq("stuck_sync_fail", sync_fail, 1);
    check_eq("stuck_bits", bit_count, 0);

    // abort at measured bit 300, then restart
    start_test(1000);
    run(0, -1, -1, -1, -1, -2, 0, 300);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_locked", locked, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_gen_en", gen_en, 0);
    check_eq("abort_bits_held", bit_count, 300);
    tick();
    check_eq("abort_idle_busy", busy, 0);
    start_test(1000);
    check_eq("restart_bits_clr", bit_count, 0);
    run(0, -1, -1, -1, -1, -2, 0, -1);
    check_eq("restart_bits", bit_count, 1000);

    // reset mid-SYNC, then zero-length test
    start_test(1000);
    rx_valid = 1'b1;
    repeat (20) tick();
    rx_valid = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    check_eq("rst2_busy", busy, 0);
    check_eq("rst2_gen_en", gen_en, 0);
    check_eq("rst2_bits", bit_count, 0);
    check_eq("rst2_resync", resync_cnt, 0);
    reset = 1'b1;
    tick();
    start_test(0);
    check_eq("zero_done", done, 1);
    check_eq("zero_busy", busy, 0);
    check_eq("zero_bits", bit_count, 0);
    check_eq("zero_errs", err_count, 0);
    check_eq("zero_sync_fail", sync_fail, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bert_seq_ctrl.md
Name: bert_seq_ctrl

Overview:
Test sequencer for the PRBS-13 bit-error-ratio tester. It loads and enables the transmit PRBS-13 generator, then self-synchronises a local PRBS-13 reference to the received serial stream. It then counts measured bits and bit errors over a programmed test length. Lock is re-acquired automatically on burst errors, and the block reports done, lock and sync-failure status to the host/register interface.

Parameters:
SEED, 13'h000F, generator load value; 13'h0000 is replaced by 13'h0001 at load
SYNC_LEN, 32, consecutive correct predictions required to declare lock
SYNC_TIMEOUT, 4096, maximum rx_valid bits spent in SYNC before failing
WIN_LEN, 64, loss-of-lock observation window, in measured bits
LOSS_ERRS, 8, errors within one window that force resync
CNT_W, 32, width of the bit and error counters

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse; begin or restart a test
abort  in  1  one-cycle pulse; return to IDLE
test_len  in  CNT_W  number of bits to measure, latched on start
rx_valid  in  1  rx_bit qualifier
rx_bit  in  1  received serial bit
gen_load  out  1  one-cycle load strobe to the PRBS-13 generator
gen_seed  out  13  seed value presented with gen_load
gen_en  out  1  generator shift enable
busy  out  1  high in LOAD, SYNC and MEAS
locked  out  1  high in MEAS
done  out  1  level; test finished, held until start or abort
sync_fail  out  1  level; SYNC timed out, valid while done
resync_cnt  out  8  loss-of-lock events in this test, saturating
bit_count  out  CNT_W  measured bits, saturating
err_count  out  CNT_W  errored bits, saturating

Behaviour:
- Reset (reset==0 at a clock edge):
  - state IDLE; all outputs 0; gen_seed=SEED (0 mapped to 1); local LFSR 0; all internal counters 0.
- PRBS-13 rule shared with the generator:
  - pred = s[12]^s[3]^s[2]^s[0].
  - The serial bit is pred; next s = {s[11:0], bit}.
- IDLE:
  - start -> LOAD. On start: latch test_len; clear bit_count, err_count, resync_cnt, sync_fail, done.
- LOAD, exactly 1 cycle:
  - gen_load=1.
  - If latched test_len==0 -> DONE with all counts 0. Otherwise -> SYNC.
- SYNC:
  - gen_en=1; only cycles with rx_valid=1 act.
  - Each valid bit: compare rx_bit with pred(s), then load s={s[11:0], rx_bit}.
  - Match counter increments on a match only once fill>=13 and s!=0. Otherwise it is cleared. The all-zero stream never locks.
  - Match counter reaching SYNC_LEN -> MEAS; locked=1 from the next cycle.
  - Timeout counter counts valid bits in SYNC. At SYNC_TIMEOUT -> DONE with sync_fail=1.
  - Timeout counter and fill counter clear on each entry to SYNC.
- MEAS:
  - Each valid bit: err = rx_bit ^ pred(s); s={s[11:0], pred(s)} (free-running, not rx-driven).
  - bit_count+1; err_count+err. Both saturate at all-ones.
  - Window counter counts to WIN_LEN, then clears the window error counter.
  - Window error count reaching LOSS_ERRS -> SYNC. resync_cnt+1 (saturating at 255). bit_count and err_count are held, not cleared.
  - bit_count reaching the latched test_len (on the update that makes it equal) -> DONE. If that same bit also trips loss, DONE wins.
- DONE:
  - done=1, gen_en=0; counters frozen.
  - start -> LOAD (full restart).
- abort:
  - In any state, abort -> IDLE next cycle, taking priority over start and all other transitions.
  - Counts are held; done=0, gen_en=0.
- start in LOAD/SYNC/MEAS is ignored; abort first.
- rx_valid=0: no counter, LFSR or state change from rx logic.
- Latency:
  - gen_load is asserted the cycle after start.
  - err_count reflects a bit on the cycle after its rx_valid edge.

Decomposition:
- Shared package bert_pkg: PRBS13 tap constant (bits 12,3,2,0), PRBS_W=13, the state enum {IDLE, LOAD, SYNC, MEAS, DONE}, and a prbs13_next function.
- One natural sub-module, prbs13_ref: a 13-bit local LFSR with a shift-enable and a mode input (rx-driven vs. free-running), outputting pred and s==0.

Test Plan:
- Clean loopback: SEED=13'h000F, ideal generator model, test_len=1000.
  - Required: gen_load pulse once; locked after 13+32 valid bits; done with bit_count=1000, err_count=0, resync_cnt=0.
- Single-bit errors: flip rx bits 100, 500 and 900 of the measured stream.
  - Required: err_count=3, resync_cnt=0, bit_count=1000.
- Burst error: invert 10 consecutive measured bits in one window.
  - Required: return to SYNC at the 8th error; resync_cnt=1; relock; err_count >= 8 and held across resync; done at bit_count=test_len.
- Stuck-zero input: rx_bit=0 constantly.
  - Required: never locked; after 4096 valid bits done=1, sync_fail=1, bit_count=0.
- Abort mid-MEAS at bit 300, then start.
  - Required: IDLE, busy=0, counts held at abort; the new start clears the counts and gen_load pulses again.
- Reset and zero-length test: reset low mid-SYNC, then start with test_len=0.
  - Required: after reset all outputs 0; LOAD then DONE with done=1 and counts 0.
- Gapped rx_valid: rx_valid at 50% duty.
  - Required: identical counts to the clean loopback case.
